// File: rtl/scr1_mem_ahb_bridge_pkg.sv
// rtl/scr1_mem_ahb_bridge_pkg.sv - memory-interface and AHB-Lite types shared by the bridge
package scr1_mem_ahb_bridge_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic {
        SCR1_AHB_ST_ADDR = 1'b0,
        SCR1_AHB_ST_DATA = 1'b1
    } type_scr1_ahb_state_e;

    localparam logic [1:0] SCR1_HTRANS_IDLE    = 2'b00;
    localparam logic [1:0] SCR1_HTRANS_NONSEQ  = 2'b10;
    localparam logic [2:0] SCR1_HSIZE_8B       = 3'b000;
    localparam logic [2:0] SCR1_HSIZE_16B      = 3'b001;
    localparam logic [2:0] SCR1_HSIZE_32B      = 3'b010;
    localparam logic [2:0] SCR1_HBURST_SINGLE  = 3'b000;
    localparam logic       SCR1_HRESP_OKAY     = 1'b0;
    localparam logic       SCR1_HRESP_ERROR    = 1'b1;
    localparam logic [3:0] SCR1_HPROT_DATA     = 4'b0001;

    function automatic logic [2:0] scr1_width2hsize(input type_scr1_mem_width_e w);
        case (w)
            SCR1_MEM_WIDTH_BYTE:  return SCR1_HSIZE_8B;
            SCR1_MEM_WIDTH_HWORD: return SCR1_HSIZE_16B;
            default:              return SCR1_HSIZE_32B;
        endcase
    endfunction

endpackage

// File: rtl/scr1_req_fifo.sv
// rtl/scr1_req_fifo.sv - circular request queue, any depth from 1, head visible without popping
module scr1_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    // a push at full is dropped even when a pop frees a slot this cycle
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            if (do_push & ~do_pop)      count <= count + 1'b1;
            else if (do_pop & ~do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/scr1_mem_ahb_bridge.sv
// rtl/scr1_mem_ahb_bridge.sv - queued core memory port to AHB-Lite single-transfer master
module scr1_mem_ahb_bridge
    import scr1_mem_ahb_bridge_pkg::*;
#(
    parameter int AHB_WIDTH = 32,
    parameter int REQ_DEPTH = 2,
    parameter int RESP_REG  = 1,
    parameter int WR_EN     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 req_ack,
    input  logic                 req,
    input  type_scr1_mem_cmd_e   cmd,
    input  type_scr1_mem_width_e width,
    input  logic [AHB_WIDTH-1:0] addr,
    input  logic [AHB_WIDTH-1:0] wdata,
    output logic [AHB_WIDTH-1:0] rdata,
    output type_scr1_mem_resp_e  resp,
    output logic [3:0]           hprot,
    output logic [2:0]           hburst,
    output logic [2:0]           hsize,
    output logic [1:0]           htrans,
    output logic                 hmastlock,
    output logic [AHB_WIDTH-1:0] haddr,
    output logic                 hwrite,
    output logic [AHB_WIDTH-1:0] hwdata,
    input  logic                 hready,
    input  logic [AHB_WIDTH-1:0] hrdata,
    input  logic                 hresp
);
    localparam int PLD_W = 3 + 2 * AHB_WIDTH;

    type_scr1_ahb_state_e state;
    logic [PLD_W-1:0]     push_data;
    logic [PLD_W-1:0]     head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 req_wr;
    logic                 head_wr;
    type_scr1_mem_width_e head_width;
    logic [AHB_WIDTH-1:0] head_wdata;
    logic                 issue;
    logic                 done;
    logic                 dp_wr;
    type_scr1_mem_resp_e  done_resp;
    logic [AHB_WIDTH-1:0] done_rdata;

    assign req_wr    = (WR_EN != 0) && (cmd == SCR1_MEM_CMD_WR);
    assign push_data = {req_wr, width, addr, wdata};
    assign push      = req & ~full;
    assign req_ack   = ~full;

    scr1_req_fifo #(
        .DEPTH (REQ_DEPTH),
        .WIDTH (PLD_W)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    assign head_wr    = head[PLD_W-1];
    assign head_width = type_scr1_mem_width_e'(head[PLD_W-2 -: 2]);
    assign head_wdata = head[AHB_WIDTH-1:0];

    // no new address phase may overlap either cycle of an ERROR response
    assign issue     = ~empty & ((state == SCR1_AHB_ST_ADDR) | (hresp == SCR1_HRESP_OKAY));
    assign pop       = issue & hready;
    assign done      = (state == SCR1_AHB_ST_DATA) & hready;

    assign htrans    = issue ? SCR1_HTRANS_NONSEQ : SCR1_HTRANS_IDLE;
    assign haddr     = head[2*AHB_WIDTH-1 -: AHB_WIDTH];
    assign hsize     = scr1_width2hsize(head_width);
    assign hwrite    = (WR_EN != 0) && head_wr;
    assign hburst    = SCR1_HBURST_SINGLE;
    assign hmastlock = 1'b0;
    assign hprot     = (WR_EN != 0) ? SCR1_HPROT_DATA : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SCR1_AHB_ST_ADDR;
            dp_wr  <= 1'b0;
            hwdata <= '0;
        end else if (pop) begin
            state  <= SCR1_AHB_ST_DATA;
            dp_wr  <= hwrite;
            hwdata <= (WR_EN != 0) ? head_wdata : '0;
        end else if (done) begin
            state  <= SCR1_AHB_ST_ADDR;
        end
    end

    assign done_resp  = !done                       ? SCR1_MEM_RESP_NOTRDY :
                        (hresp == SCR1_HRESP_ERROR) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
    assign done_rdata = (done & ~dp_wr) ? hrdata : '0;

    generate
        if (RESP_REG != 0) begin : g_resp_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    resp  <= SCR1_MEM_RESP_NOTRDY;
                    rdata <= '0;
                end else begin
                    resp  <= done_resp;
                    rdata <= done_rdata;
                end
            end
        end else begin : g_resp_comb
            assign resp  = done_resp;
            assign rdata = done_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_scr1_mem_ahb_bridge.sv
// tb/tb_scr1_mem_ahb_bridge.sv - bench for scr1_mem_ahb_bridge with a reactive AHB slave and queue model
module tb_scr1_mem_ahb_bridge;
    import scr1_mem_ahb_bridge_pkg::*;

    localparam int DEPTH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, req, req_ack, hready, hresp, hmastlock, hwrite;
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e width;
    type_scr1_mem_resp_e  resp;
    logic [31:0]          addr, wdata, rdata, haddr, hwdata, hrdata;
    logic [3:0]           hprot;
    logic [2:0]           hburst, hsize;
    logic [1:0]           htrans;

    scr1_mem_ahb_bridge #(
        .AHB_WIDTH (32),
        .REQ_DEPTH (DEPTH),
        .RESP_REG  (1),
        .WR_EN     (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_ack   (req_ack),
        .req       (req),
        .cmd       (cmd),
        .width     (width),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .resp      (resp),
        .hprot     (hprot),
        .hburst    (hburst),
        .hsize     (hsize),
        .htrans    (htrans),
        .hmastlock (hmastlock),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hwdata    (hwdata),
        .hready    (hready),
        .hrdata    (hrdata),
        .hresp     (hresp)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          waits;
        bit          err;
        logic [31:0] rdata;
    } plan_t;

    req_t        iss_q[$];
    plan_t       plan_q[$];
    logic [31:0] issued_log[$];
    type_scr1_mem_resp_e resp_log[$];

    bit          dp_valid, dp_err_seen, idle_stall, exp_rd;
    req_t        dp_req;
    plan_t       dp_plan;
    type_scr1_mem_resp_e exp_resp;
    logic [31:0] exp_rdata;
    int          wait_max, err_pct;
    int          n_checks, n_fail, n_accept, n_comp, err_idle;

    logic        s_req_ack, s_hwrite;
    logic [1:0]  s_htrans;
    logic [2:0]  s_hsize;
    logic [31:0] s_haddr, s_hwdata, s_rdata;
    type_scr1_mem_resp_e s_resp;

    function automatic plan_t mk_plan(input int w, input bit e, input logic [31:0] d);
        plan_t p;
        p.waits = w;
        p.err   = e;
        p.rdata = d;
        return p;
    endfunction

    task automatic drive_req(input bit v, input bit wr, input logic [1:0] w,
                             input logic [31:0] a, input logic [31:0] d);
        req   = v;
        cmd   = wr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
        width = type_scr1_mem_width_e'(w);
        addr  = a;
        wdata = d;
    endtask

    // One clock: slave drives, outputs checked against the queue model, then edge events applied.
    task automatic run_cycle();
        bit   exp_nonseq, accepted;
        req_t r;
        if (dp_valid) begin
            if (dp_plan.waits > 0) begin hready = 1'b0; hresp = 1'b0; end
            else if (dp_plan.err)  begin hready = dp_err_seen; hresp = 1'b1; end
            else                   begin hready = 1'b1; hresp = 1'b0; end
            hrdata = dp_plan.rdata;
        end else begin
            hready = ~idle_stall;
            hresp  = 1'b0;
            hrdata = $urandom;
        end
        @(negedge clk);
        s_req_ack = req_ack; s_htrans = htrans; s_haddr = haddr; s_hsize = hsize;
        s_hwrite = hwrite; s_hwdata = hwdata; s_resp = resp; s_rdata = rdata;
        exp_nonseq = (iss_q.size() != 0) && !(dp_valid && hresp);
        if (rst) begin
            iss_q.delete();
            plan_q.delete();
            dp_valid = 0;
            exp_resp = SCR1_MEM_RESP_NOTRDY;
        end else begin
            n_checks++;
            if (s_req_ack !== (iss_q.size() < DEPTH)) begin
                n_fail++; $display("FAIL model_req_ack t=%0t got %b want %b", $time, s_req_ack, iss_q.size() < DEPTH);
            end
            n_checks++;
            if (s_htrans !== (exp_nonseq ? 2'b10 : 2'b00)) begin
                n_fail++; $display("FAIL model_htrans t=%0t got %b want nonseq=%b", $time, s_htrans, exp_nonseq);
            end
            if (exp_nonseq) begin
                n_checks++;
                if (s_haddr !== iss_q[0].addr || s_hsize !== {1'b0, iss_q[0].size} || s_hwrite !== iss_q[0].wr) begin
                    n_fail++; $display("FAIL model_addr_phase t=%0t got %h/%0d/%b want %h/%0d/%b", $time,
                                       s_haddr, s_hsize, s_hwrite, iss_q[0].addr, iss_q[0].size, iss_q[0].wr);
                end
            end
            if (dp_valid && dp_req.wr) begin
                n_checks++;
                if (s_hwdata !== dp_req.wdata) begin
                    n_fail++; $display("FAIL model_hwdata t=%0t got %h want %h", $time, s_hwdata, dp_req.wdata);
                end
            end
            n_checks++;
            if (s_resp !== exp_resp) begin
                n_fail++; $display("FAIL model_resp t=%0t got %0d want %0d", $time, s_resp, exp_resp);
            end else if (exp_resp == SCR1_MEM_RESP_RDY_OK && exp_rd) begin
                n_checks++;
                if (s_rdata !== exp_rdata) begin
                    n_fail++; $display("FAIL model_rdata t=%0t got %h want %h", $time, s_rdata, exp_rdata);
                end
            end
            if (s_resp != SCR1_MEM_RESP_NOTRDY) resp_log.push_back(s_resp);
            if (dp_valid && hresp && s_htrans == 2'b00) err_idle++;

            accepted = req && (iss_q.size() < DEPTH);
            exp_resp = SCR1_MEM_RESP_NOTRDY;
            if (dp_valid && hready) begin
                exp_resp  = hresp ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                exp_rd    = !dp_req.wr;
                exp_rdata = dp_plan.rdata;
                dp_valid  = 0;
                n_comp++;
            end else if (dp_valid) begin
                if (dp_plan.waits > 0) dp_plan.waits--;
                else dp_err_seen = 1;
            end
            if (exp_nonseq && hready) begin
                dp_req = iss_q.pop_front();
                issued_log.push_back(dp_req.addr);
                if (plan_q.size() != 0) dp_plan = plan_q.pop_front();
                else dp_plan = mk_plan($urandom_range(0, wait_max), $urandom_range(0, 99) < err_pct, $urandom);
                dp_valid    = 1;
                dp_err_seen = 0;
            end
            if (accepted) begin
                r.wr = (cmd == SCR1_MEM_CMD_WR); r.size = width; r.addr = addr; r.wdata = wdata;
                iss_q.push_back(r);
                n_accept++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard = 0;
        req = 1'b0;
        while ((iss_q.size() != 0 || dp_valid || exp_resp != SCR1_MEM_RESP_NOTRDY) && guard < 200) begin
            run_cycle();
            guard++;
        end
        n_checks++;
        if (guard >= 200) begin
            n_fail++; $display("FAIL drain_timeout outstanding=%0d want 0", iss_q.size());
        end
        run_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_req(0, 0, 2, 0, 0);
        run_cycle();
        run_cycle();
        rst = 1'b0;
        run_cycle();
        n_checks++;
        if (s_htrans !== 2'b00 || s_resp !== SCR1_MEM_RESP_NOTRDY || s_req_ack !== 1'b1) begin
            n_fail++; $display("FAIL reset_state htrans=%b resp=%0d ack=%b want 00/0/1", s_htrans, s_resp, s_req_ack);
        end
        n_checks++;
        if (hburst !== 3'b000 || hmastlock !== 1'b0 || hprot !== 4'b0001) begin
            n_fail++; $display("FAIL reset_consts hburst=%0d hmastlock=%b hprot=%b want 0/0/0001", hburst, hmastlock, hprot);
        end
    endtask

    task automatic test_single_read();
        plan_q.push_back(mk_plan(0, 0, 32'hDEADBEEF));
        drive_req(1, 0, 2, 32'h100, 0);
        run_cycle();
        n_checks++;
        if (s_req_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack got %b want 1", s_req_ack); end
        req = 1'b0;
        run_cycle();
        n_checks++;
        if (s_htrans !== 2'b10 || s_haddr !== 32'h100) begin
            n_fail++; $display("FAIL single_addr_phase htrans=%b haddr=%h want 10/00000100", s_htrans, s_haddr);
        end
        run_cycle();
        n_checks++;
        if (s_resp !== SCR1_MEM_RESP_NOTRDY) begin n_fail++; $display("FAIL single_early_resp got %0d want 0", s_resp); end
        run_cycle();
        n_checks++;
        if (s_resp !== SCR1_MEM_RESP_RDY_OK || s_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_resp resp=%0d rdata=%h want 1/deadbeef", s_resp, s_rdata);
        end
        drain();
    endtask

    task automatic test_fill();
        idle_stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive_req(1, 0, 2, 32'(4 * i), 0);
            run_cycle();
            n_checks++;
            if (s_req_ack !== 1'b1) begin n_fail++; $display("FAIL fill_ack_%0d got %b want 1", i, s_req_ack); end
        end
        drive_req(1, 0, 2, 32'hC, 0);
        run_cycle();
        n_checks++;
        if (s_req_ack !== 1'b0) begin n_fail++; $display("FAIL fill_full_ack got %b want 0", s_req_ack); end
        req = 1'b0;
        idle_stall = 0;
        issued_log.delete();
        resp_log.delete();
        run_cycle();
        n_checks++;
        if (s_req_ack !== 1'b0 || s_htrans !== 2'b10) begin
            n_fail++; $display("FAIL fill_first_pop ack=%b htrans=%b want 0/10", s_req_ack, s_htrans);
        end
        run_cycle();
        n_checks++;
        if (s_req_ack !== 1'b1) begin n_fail++; $display("FAIL fill_ack_reassert got %b want 1", s_req_ack); end
        drain();
        n_checks++;
        if (issued_log.size() != 3 || issued_log[0] !== 32'h0 || issued_log[1] !== 32'h4 || issued_log[2] !== 32'h8) begin
            n_fail++; $display("FAIL fill_order issued=%0d want 3 in order 0,4,8", issued_log.size());
        end
        n_checks++;
        if (resp_log.size() != 3) begin n_fail++; $display("FAIL fill_resp_count got %0d want 3", resp_log.size()); end
    endtask

    task automatic test_write_byte();
        plan_q.push_back(mk_plan(0, 0, 32'h0));
        drive_req(1, 1, 0, 32'h203, 32'h11000000);
        run_cycle();
        req = 1'b0;
        run_cycle();
        n_checks++;
        if (s_htrans !== 2'b10 || s_hsize !== 3'b000 || s_hwrite !== 1'b1 || s_haddr !== 32'h203) begin
            n_fail++; $display("FAIL wbyte_addr_phase htrans=%b hsize=%0d hwrite=%b haddr=%h want 10/0/1/203",
                               s_htrans, s_hsize, s_hwrite, s_haddr);
        end
        run_cycle();
        n_checks++;
        if (s_hwdata !== 32'h11000000) begin n_fail++; $display("FAIL wbyte_hwdata got %h want 11000000", s_hwdata); end
        run_cycle();
        n_checks++;
        if (s_resp !== SCR1_MEM_RESP_RDY_OK) begin n_fail++; $display("FAIL wbyte_resp got %0d want 1", s_resp); end
        drain();
    endtask

    task automatic test_error();
        plan_q.push_back(mk_plan(0, 0, $urandom));
        plan_q.push_back(mk_plan(0, 1, $urandom));
        plan_q.push_back(mk_plan(0, 0, $urandom));
        issued_log.delete();
        resp_log.delete();
        err_idle = 0;
        for (int i = 0; i < 3; i++) begin
            drive_req(1, 0, 2, 32'h300 + 32'(4 * i), 0);
            run_cycle();
        end
        drain();
        n_checks++;
        if (resp_log.size() != 3 || resp_log[0] !== SCR1_MEM_RESP_RDY_OK ||
            resp_log[1] !== SCR1_MEM_RESP_RDY_ER || resp_log[2] !== SCR1_MEM_RESP_RDY_OK) begin
            n_fail++; $display("FAIL err_resp_seq count=%0d want OK,ER,OK", resp_log.size());
        end
        n_checks++;
        if (err_idle != 2) begin n_fail++; $display("FAIL err_idle_cycles got %0d want 2", err_idle); end
        n_checks++;
        if (issued_log.size() != 3 || issued_log[2] !== 32'h308) begin
            n_fail++; $display("FAIL err_third_issue issued=%0d want 3 ending 308", issued_log.size());
        end
    endtask

    task automatic test_back_to_back();
        wait_max = 0;
        err_pct  = 0;
        for (int i = 0; i < 8; i++) begin
            drive_req(1, $urandom_range(0, 1), 2, {$urandom_range(0, 255), 2'b00}, $urandom);
            run_cycle();
            if (i > 0) begin
                n_checks++;
                if (s_htrans !== 2'b10 || s_req_ack !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_cycle_%0d htrans=%b ack=%b want 10/1", i, s_htrans, s_req_ack);
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        plan_q.push_back(mk_plan(20, 0, 32'h12345678));
        drive_req(1, 0, 2, 32'h400, 0);
        run_cycle();
        req = 1'b0;
        run_cycle();
        run_cycle();
        run_cycle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        resp_log.delete();
        run_cycle();
        n_checks++;
        if (s_htrans !== 2'b00 || s_resp !== SCR1_MEM_RESP_NOTRDY || s_req_ack !== 1'b1) begin
            n_fail++; $display("FAIL midrst_state htrans=%b resp=%0d ack=%b want 00/0/1", s_htrans, s_resp, s_req_ack);
        end
        repeat (10) run_cycle();
        n_checks++;
        if (resp_log.size() != 0) begin n_fail++; $display("FAIL midrst_stale_resp got %0d want 0", resp_log.size()); end
    endtask

    task automatic test_random();
        int a0, c0, w;
        wait_max = 2;
        err_pct  = 15;
        a0 = n_accept;
        c0 = n_comp;
        for (int i = 0; i < 400; i++) begin
            w = $urandom_range(0, 2);
            drive_req($urandom_range(0, 99) < 60, $urandom_range(0, 1), 2'(w),
                      ($urandom & 32'h0000FFFF) & ~((32'd1 << w) - 32'd1), $urandom);
            run_cycle();
        end
        drain();
        n_checks++;
        if ((n_comp - c0) != (n_accept - a0) || (n_accept - a0) == 0) begin
            n_fail++; $display("FAIL random_completions got %0d want %0d (nonzero)", n_comp - c0, n_accept - a0);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_accept = 0; n_comp = 0; err_idle = 0;
        dp_valid = 0; dp_err_seen = 0; idle_stall = 0; exp_rd = 0;
        exp_resp = SCR1_MEM_RESP_NOTRDY; exp_rdata = '0;
        wait_max = 0; err_pct = 0;
        rst = 1'b1; hready = 1'b1; hresp = 1'b0; hrdata = '0;
        drive_req(0, 0, 2, 0, 0);
        test_reset();
        test_single_read();
        test_fill();
        test_write_byte();
        test_error();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
